banner_scanout: RTL and testbench

- Reader for the 1440-bit effect-name banner bitmap (12 rows x 120 columns) built by the font-lookup text block.
- On a start pulse, snapshots the bitmap and streams it out one pixel per beat over a valid/ready handshake.
- Stream order is row-major, with integer up-scaling in x and y.
- Sits between the banner text generator and the VGA overlay/frame-buffer writer.

---
 rtl/banner_scanout.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_banner_scanout.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/banner_scanout.sv
// ============================================================================
// banner_scanout
// ----------------------------------------------------------------------------
// Reads the effect-name banner bitmap (ROWS x COLS, one bit per pixel) built
// by the font-lookup text block and streams it to the VGA overlay /
// frame-buffer writer, one pixel per beat over a valid/ready handshake.
//
// On a start pulse in IDLE the bitmap is copied into a private snapshot.
// The frame in progress is therefore immune to later pixel_map changes. The
// snapshot is then walked row-major with integer up-scaling: each bitmap
// pixel is repeated SCALE times along x, and each bitmap row is re-read SCALE
// times along y. A frame is COLS*ROWS*SCALE*SCALE beats.
//
// Parameters:
//   COLS  - bitmap columns (10 glyphs x 12 px = 120)
//   ROWS  - bitmap rows (12)
//   SCALE - replication factor in x and y, >= 1
//
// Ports:
//   Clk        in   system clock
//   Reset      in   synchronous, active-high reset
//   invert     in   (only with BANNER_SCAN_INVERT_EN) complement the frame's
//                   pixels; sampled together with pixel_map on start
//   start      in   one-cycle request to begin a frame scan (IDLE only)
//   pixel_map  in   banner bitmap; row r, column c is bit
//                   (ROWS-r)*COLS-1-c (row 0 in the MSBs, column 0 = MSB)
//   pix_valid  out  beat outputs below are valid
//   pix_ready  in   downstream accepts the beat when high with pix_valid
//   pix_data   out  pixel value, 1 = foreground
//   pix_x      out  scaled x coordinate, 0..COLS*SCALE-1
//   pix_y      out  scaled y coordinate, 0..ROWS*SCALE-1
//   line_last  out  last beat of a scaled line
//   frame_last out  last beat of the frame
//   busy       out  high while the frame is being streamed
//   done       out  one-cycle pulse after the final beat is accepted
//
// Optional feature macro: BANNER_SCAN_INVERT_EN (adds the invert input).
// ============================================================================
module banner_scanout #(
    parameter int COLS  = 120,
    parameter int ROWS  = 12,
    parameter int SCALE = 2
) (
    input  logic                            Clk,
    input  logic                            Reset,
`ifdef BANNER_SCAN_INVERT_EN
    input  logic                            invert,
`endif
    input  logic                            start,
    input  logic [COLS*ROWS-1:0]            pixel_map,
    output logic                            pix_valid,
    input  logic                            pix_ready,
    output logic                            pix_data,
    output logic [$clog2(COLS*SCALE)-1:0]   pix_x,
    output logic [$clog2(ROWS*SCALE)-1:0]   pix_y,
    output logic                            line_last,
    output logic                            frame_last,
    output logic                            busy,
    output logic                            done
);

    localparam int NPIX = COLS * ROWS;
    localparam int XW   = $clog2(COLS * SCALE);
    localparam int YW   = $clog2(ROWS * SCALE);
    // Counter widths are clamped to 1 bit so a degenerate dimension of 1
    // still yields a legal (always-zero) counter.
    localparam int CW   = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int RW   = (ROWS  > 1) ? $clog2(ROWS)  : 1;
    localparam int SW   = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int IW   = (NPIX  > 1) ? $clog2(NPIX)  : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [SW-1:0] REP_LAST = SW'(SCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [NPIX-1:0]     snap_q,       snap_d;
    logic [CW-1:0]       col_q,        col_d;
    logic [RW-1:0]       row_q,        row_d;
    logic [SW-1:0]       hrep_q,       hrep_d;
    logic [SW-1:0]       vrep_q,       vrep_d;
    logic                pix_valid_q,  pix_valid_d;
    logic                pix_data_q,   pix_data_d;
    logic [XW-1:0]       pix_x_q,      pix_x_d;
    logic [YW-1:0]       pix_y_q,      pix_y_d;
    logic                line_last_q,  line_last_d;
    logic                frame_last_q, frame_last_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
`ifdef BANNER_SCAN_INVERT_EN
    logic                inv_q,        inv_d;
`endif

    // Successor of the current counter set after one accepted beat
    logic [CW-1:0]       col_adv;
    logic [RW-1:0]       row_adv;
    logic [SW-1:0]       hrep_adv;
    logic [SW-1:0]       vrep_adv;

    // Counter set / source bitmap used to build the next beat's outputs
    logic                load_beat;
    logic                clear_beat;
    logic [CW-1:0]       sel_col;
    logic [RW-1:0]       sel_row;
    logic [SW-1:0]       sel_hrep;
    logic [SW-1:0]       sel_vrep;
    logic [NPIX-1:0]     sel_map;
    logic                sel_inv;
    logic                sel_line_last;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Bitmap lookup using the row-0-in-MSBs, column-0-is-MSB layout.
    function automatic logic map_bit(input logic [NPIX-1:0] map,
                                     input logic [RW-1:0]   r,
                                     input logic [CW-1:0]   c);
        logic [IW-1:0] idx;
        idx = IW'((ROWS - 1 - int'(r)) * COLS + (COLS - 1 - int'(c)));
        return map[idx];
    endfunction

    function automatic logic [XW-1:0] scaled_x(input logic [CW-1:0] c,
                                               input logic [SW-1:0] h);
        return XW'(int'(c) * SCALE + int'(h));
    endfunction

    function automatic logic [YW-1:0] scaled_y(input logic [RW-1:0] r,
                                               input logic [SW-1:0] v);
        return YW'(int'(r) * SCALE + int'(v));
    endfunction

    // ------------------------------------------------------------------------
    // Counter advance: hrep is the fastest digit, then col, then vrep, then
    // row. Replaying vrep before row means each bitmap row is re-read SCALE
    // times to build SCALE identical scaled lines.
    // ------------------------------------------------------------------------
    always_comb begin
        col_adv  = col_q;
        row_adv  = row_q;
        hrep_adv = hrep_q;
        vrep_adv = vrep_q;
        if (hrep_q == REP_LAST) begin
            hrep_adv = '0;
            if (col_q == COL_LAST) begin
                col_adv = '0;
                if (vrep_q == REP_LAST) begin
                    vrep_adv = '0;
                    if (row_q == ROW_LAST) begin
                        row_adv = '0;
                    end else begin
                        row_adv = row_q + 1'b1;
                    end
                end else begin
                    vrep_adv = vrep_q + 1'b1;
                end
            end else begin
                col_adv = col_q + 1'b1;
            end
        end else begin
            hrep_adv = hrep_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic. All beat outputs are registered: whenever
    // a new beat must appear (start accepted, or a beat accepted mid-frame)
    // the outputs are rebuilt from the counter set that beat will hold. A
    // stalled beat simply keeps its registers.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        col_d        = col_q;
        row_d        = row_q;
        hrep_d       = hrep_q;
        vrep_d       = vrep_q;
        pix_valid_d  = pix_valid_q;
        pix_data_d   = pix_data_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        line_last_d  = line_last_q;
        frame_last_d = frame_last_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
`ifdef BANNER_SCAN_INVERT_EN
        inv_d        = inv_q;
        sel_inv      = inv_q;
`else
        sel_inv      = 1'b0;
`endif
        load_beat    = 1'b0;
        clear_beat   = 1'b0;
        sel_col      = col_q;
        sel_row      = row_q;
        sel_hrep     = hrep_q;
        sel_vrep     = vrep_q;
        sel_map      = snap_q;

        case (state_q)
            ST_IDLE: begin
                pix_valid_d = 1'b0;
                busy_d      = 1'b0;
                clear_beat  = 1'b1;
                if (start) begin
                    // The first beat is built straight from the live inputs
                    // so it can appear one cycle after start.
                    snap_d      = pixel_map;
                    col_d       = '0;
                    row_d       = '0;
                    hrep_d      = '0;
                    vrep_d      = '0;
                    sel_col     = '0;
                    sel_row     = '0;
                    sel_hrep    = '0;
                    sel_vrep    = '0;
                    sel_map     = pixel_map;
`ifdef BANNER_SCAN_INVERT_EN
                    inv_d       = invert;
                    sel_inv     = invert;
`endif
                    pix_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    clear_beat  = 1'b0;
                    load_beat   = 1'b1;
                    state_d     = ST_STREAM;
                end
            end

            ST_STREAM: begin
                if (pix_valid_q && pix_ready) begin
                    if (frame_last_q) begin
                        pix_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        clear_beat  = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        col_d     = col_adv;
                        row_d     = row_adv;
                        hrep_d    = hrep_adv;
                        vrep_d    = vrep_adv;
                        sel_col   = col_adv;
                        sel_row   = row_adv;
                        sel_hrep  = hrep_adv;
                        sel_vrep  = vrep_adv;
                        load_beat = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // done_q is high for exactly this one cycle
                clear_beat = 1'b1;
                state_d    = ST_IDLE;
            end

            default: begin
                pix_valid_d = 1'b0;
                busy_d      = 1'b0;
                clear_beat  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase

        sel_line_last = (sel_col == COL_LAST) && (sel_hrep == REP_LAST);

        if (load_beat) begin
            pix_data_d   = map_bit(sel_map, sel_row, sel_col) ^ sel_inv;
            pix_x_d      = scaled_x(sel_col, sel_hrep);
            pix_y_d      = scaled_y(sel_row, sel_vrep);
            line_last_d  = sel_line_last;
            frame_last_d = sel_line_last && (sel_row == ROW_LAST)
                                         && (sel_vrep == REP_LAST);
        end else if (clear_beat) begin
            pix_data_d   = 1'b0;
            pix_x_d      = '0;
            pix_y_d      = '0;
            line_last_d  = 1'b0;
            frame_last_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State register with synchronous reset. Reset mid-frame drops straight
    // back to IDLE with no done pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            snap_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            hrep_q       <= '0;
            vrep_q       <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            line_last_q  <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef BANNER_SCAN_INVERT_EN
            inv_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hrep_q       <= hrep_d;
            vrep_q       <= vrep_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            line_last_q  <= line_last_d;
            frame_last_q <= frame_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef BANNER_SCAN_INVERT_EN
            inv_q        <= inv_d;
`endif
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign line_last  = line_last_q;
    assign frame_last = frame_last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_banner_scanout.sv
// ============================================================================
// tb_banner_scanout
// ----------------------------------------------------------------------------
// Directed bench for banner_scanout at default parameters (120x12, SCALE 2).
// Expected beats come from the bitmap layout itself: beat n sits at
// x = n % 240, y = n / 240 and shows bit (12 - y/2)*120 - 1 - x/2 of the map
// captured at start.
// ============================================================================
module tb_banner_scanout;

    localparam int COLS  = 120;
    localparam int ROWS  = 12;
    localparam int SCALE = 2;
    localparam int W     = COLS * SCALE;
    localparam int H     = ROWS * SCALE;
    localparam int NB    = W * H;
    localparam int NPIX  = COLS * ROWS;
    localparam int CYCLE_BUDGET = 20000;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            start;
    logic [NPIX-1:0] pixel_map;
    logic            pix_valid;
    logic            pix_ready;
    logic            pix_data;
    logic [7:0]      pix_x;
    logic [4:0]      pix_y;
    logic            line_last;
    logic            frame_last;
    logic            busy;
    logic            done;
`ifdef BANNER_SCAN_INVERT_EN
    logic            invert;
`endif

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference state for the frame under test
    logic [NPIX-1:0] refMap;
    logic            refInv;

    // Results gathered by streamFrame
    int beats, badBeats, lineCount, stallBad, onesCount, flX, flY;
    bit endedByReset, timedOut;

    banner_scanout #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .SCALE (SCALE)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
`ifdef BANNER_SCAN_INVERT_EN
        .invert     (invert),
`endif
        .start      (start),
        .pixel_map  (pixel_map),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .line_last  (line_last),
        .frame_last (frame_last),
        .busy       (busy),
        .done       (done)
    );

    // Free-running 100 MHz clock
    always #5 Clk = ~Clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Pulse start with a new bitmap and confirm the first beat appears
    // one cycle later
    task automatic applyStimulus(input logic [NPIX-1:0] map);
        pixel_map = map;
        refMap    = map;
        start     = 1'b1;
        @(posedge Clk); #1;
        start     = 1'b0;
        checkOutput("first_valid", 32'(pix_valid), 32'd1);
        checkOutput("first_busy",  32'(busy),      32'd1);
    endtask

    // Consume beats until pix_valid drops, checking each presented beat
    // against the reference and that stalled beats hold still. Optionally
    // disturbs pixel_map/start or asserts Reset at a given beat index.
    task automatic streamFrame(input bit randomReady, input int disturbAt,
                               input int resetAt);
        int         cycles, ex, ey, idx;
        bit         stalled, disturbed;
        logic [7:0] hx;
        logic [4:0] hy;
        logic       hd, hll, hfl, expData;
        beats = 0; badBeats = 0; lineCount = 0; stallBad = 0; onesCount = 0;
        flX = -1; flY = -1; endedByReset = 0; timedOut = 0;
        cycles = 0; stalled = 0; disturbed = 0;
        hx = '0; hy = '0; hd = 0; hll = 0; hfl = 0;
        while (pix_valid === 1'b1) begin
            if (cycles >= CYCLE_BUDGET) begin
                timedOut = 1;
                break;
            end
            ex  = beats % W;
            ey  = beats / W;
            idx = (ROWS - ey / SCALE) * COLS - 1 - ex / SCALE;
            expData = refMap[idx] ^ refInv;
            if (pix_x !== 8'(ex) || pix_y !== 5'(ey) || pix_data !== expData ||
                line_last !== (ex == W - 1) || frame_last !== (beats == NB - 1) ||
                busy !== 1'b1 || done !== 1'b0)
                badBeats++;
            if (stalled && (pix_x !== hx || pix_y !== hy || pix_data !== hd ||
                            line_last !== hll || frame_last !== hfl))
                stallBad++;
            hx = pix_x; hy = pix_y; hd = pix_data; hll = line_last; hfl = frame_last;
            pix_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (beats == disturbAt && !disturbed) begin
                pixel_map = ~refMap;
                start     = 1'b1;
                disturbed = 1;
            end
            if (beats == resetAt) Reset = 1'b1;
            @(posedge Clk); #1;
            start = 1'b0;
            cycles++;
            if (Reset) begin
                Reset = 1'b0;
                endedByReset = 1;
                break;
            end
            if (pix_ready) begin
                if (hd)  onesCount++;
                if (hll) lineCount++;
                if (hfl) begin
                    flX = hx;
                    flY = hy;
                end
                beats++;
                stalled = 0;
            end else begin
                stalled = 1;
            end
        end
        pix_ready = 1'b1;
    endtask

    // Full frame plus completion checks
    task automatic runFullFrame(input string name, input logic [NPIX-1:0] map,
                                input bit randomReady, input int disturbAt);
        int expOnes;
        applyStimulus(map);
        streamFrame(randomReady, disturbAt, -1);
        expOnes = refInv ? NB - 4 * $countones(refMap) : 4 * $countones(refMap);
        checkOutput({name, "_timeout"},   32'(timedOut),  32'd0);
        checkOutput({name, "_beats"},     32'(beats),     32'(NB));
        checkOutput({name, "_bad_beats"}, 32'(badBeats),  32'd0);
        checkOutput({name, "_lines"},     32'(lineCount), 32'(H));
        checkOutput({name, "_stall"},     32'(stallBad),  32'd0);
        checkOutput({name, "_ones"},      32'(onesCount), 32'(expOnes));
        checkOutput({name, "_done"},      32'(done),      32'd1);
        checkOutput({name, "_busy_end"},  32'(busy),      32'd0);
        @(posedge Clk); #1;
        checkOutput({name, "_done_once"}, 32'(done),      32'd0);
        checkOutput({name, "_idle"},      32'(pix_valid), 32'd0);
    endtask

    logic [NPIX-1:0] mapTop, mapBottom, mapRand;
    int doneSeen;

    initial begin
        Reset = 1'b1; start = 1'b0; pix_ready = 1'b1; pixel_map = '0;
        refMap = '0; refInv = 1'b0;
`ifdef BANNER_SCAN_INVERT_EN
        invert = 1'b0;
`endif
        mapTop = '0;    mapTop[NPIX-1] = 1'b1;
        mapBottom = '0; mapBottom[0]   = 1'b1;
        for (int i = 0; i < NPIX; i += 32) mapRand[i +: 32] = $urandom;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_valid",      32'(pix_valid),  32'd0);
        checkOutput("rst_busy",       32'(busy),       32'd0);
        checkOutput("rst_done",       32'(done),       32'd0);
        checkOutput("rst_data",       32'(pix_data),   32'd0);
        checkOutput("rst_x",          32'(pix_x),      32'd0);
        checkOutput("rst_y",          32'(pix_y),      32'd0);
        checkOutput("rst_line_last",  32'(line_last),  32'd0);
        checkOutput("rst_frame_last", 32'(frame_last), 32'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        checkOutput("idle_valid", 32'(pix_valid), 32'd0);

        // Top-left pixel only: foreground at x,y in {0,1}
        $display("[TB] top-left pixel frame");
        runFullFrame("top", mapTop, 1'b0, -1);

        // Bottom-right pixel only: foreground at the last 2x2 block,
        // frame_last on (239,23)
        $display("[TB] bottom-right pixel frame");
        runFullFrame("bottom", mapBottom, 1'b0, -1);
        checkOutput("bottom_fl_x", 32'(flX), 32'd239);
        checkOutput("bottom_fl_y", 32'(flY), 32'd23);

        // Random bitmap with random backpressure
        $display("[TB] random bitmap with backpressure");
        runFullFrame("bp", mapRand, 1'b1, -1);

        // Map change plus start pulse at beat 1000 must not disturb the frame
        $display("[TB] mid-frame map change and start");
        runFullFrame("snap", mapRand, 1'b0, 1000);

        // Reset at beat 300
        $display("[TB] reset mid-frame");
        applyStimulus(mapRand);
        streamFrame(1'b0, -1, 300);
        checkOutput("mrst_taken", 32'(endedByReset), 32'd1);
        checkOutput("mrst_valid", 32'(pix_valid),    32'd0);
        checkOutput("mrst_busy",  32'(busy),         32'd0);
        doneSeen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) doneSeen++;
            @(posedge Clk); #1;
        end
        checkOutput("mrst_no_done", 32'(doneSeen), 32'd0);
        runFullFrame("after_rst", mapTop, 1'b0, -1);

`ifdef BANNER_SCAN_INVERT_EN
        // Inverted blank banner: every beat is foreground
        $display("[TB] inverted blank frame");
        invert = 1'b1;
        refInv = 1'b1;
        runFullFrame("inv", '0, 1'b0, -1);
        checkOutput("inv_all_ones", 32'(onesCount), 32'(NB));
        invert = 1'b0;
        refInv = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compareCount, mismatchCount);
        $finish;
    end

endmodule
